// File: rtl/seq_00_10_11_ctrl_if.sv
// Board pin bundle for seq_00_10_11_ctrl: raw slide switches in, LED bank out.
// The board (or bench) side takes the master modport; the controller takes the slave modport.
interface seq_00_10_11_ctrl_if;
   logic [7:0]  sw_pin;
   logic [15:0] led_pin;

   modport master (output sw_pin, input  led_pin);
   modport slave  (input  sw_pin, output led_pin);
endinterface

// File: rtl/seq_00_10_11_ctrl.sv
// "00->10->11" sequence detector for EGO1: 2-FF sync, whole-word debounce of {x2,x1}, Moore FSM, LED drive.
// Optional macro DETECT_COUNT_EN adds an 8-bit detection counter shown on led_pin[15:8].
module seq_00_10_11_ctrl #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_00_10_11_ctrl_if.slave pins
);

   localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

   // Encodings are the {y2,y1} LED pattern.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FAIL   = 2'b01,
      GOT10  = 2'b10,
      DETECT = 2'b11
   } state_t;

   logic [1:0]       sync_meta;
   logic [1:0]       sync_x;
   logic [1:0]       sync_prev;
   logic [1:0]       deb_x;
   logic [1:0]       deb_x_next;
   logic [CNT_W-1:0] deb_cnt;
   logic [CNT_W-1:0] deb_cnt_next;
   logic [CNT_W-1:0] run;
   state_t           state;
   state_t           state_next;
   logic             z;
   logic [1:0]       y;
   logic [7:0]       count_led;
   logic             unused_sw;

   // Only x2/x1 belong to this exercise; the other switches are deliberately ignored.
   assign unused_sw = ^pins.sw_pin[5:0];

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         sync_meta <= 2'b00;
         sync_x    <= 2'b00;
         sync_prev <= 2'b00;
         deb_x     <= 2'b00;
         deb_cnt   <= '0;
         state     <= IDLE;
         z         <= 1'b0;
      end else begin
         sync_meta <= pins.sw_pin[7:6];
         sync_x    <= sync_meta;
         sync_prev <= sync_x;
         deb_x     <= deb_x_next;
         deb_cnt   <= deb_cnt_next;
         state     <= state_next;
         z         <= (state_next == DETECT);
      end
   end

   // The word is debounced as a unit, so a simultaneous two-switch flip is accepted in one step.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      deb_x_next   = deb_x;
      deb_cnt_next = '0;
      run          = '0;
      if (sync_x != deb_x) begin
         run = (sync_x != sync_prev) ? CNT_W'(1) : deb_cnt + CNT_W'(1);
         if (run == CNT_W'(DEB_CYCLES)) begin
            deb_x_next = sync_x;
         end else begin
            deb_cnt_next = run;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (deb_x)
         2'b00:   state_next = IDLE;
         2'b01:   state_next = FAIL;
         2'b10:   state_next = (state == IDLE  || state == GOT10)  ? GOT10  : FAIL;
         2'b11:   state_next = (state == GOT10 || state == DETECT) ? DETECT : FAIL;
         default: state_next = state;
      endcase
   end

`ifdef DETECT_COUNT_EN
   logic [7:0] det_cnt;

   // Counts entries into DETECT only; dwelling there is not a new detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         det_cnt <= 8'd0;
      end else if (state_next == DETECT && state != DETECT) begin
         det_cnt <= det_cnt + 8'd1;
      end
   end

   assign count_led = det_cnt;
`else
   assign count_led = 8'd0;
`endif

   assign y            = state;
   assign pins.led_pin = {count_led, z, 3'b000, deb_x, y[0], y[1]};

endmodule

// File: tb/tb_seq_00_10_11_ctrl.sv
// Scoreboard bench for seq_00_10_11_ctrl: stimulus queues hand-computed LED words with their edge numbers,
// a negedge monitor pops and compares them and flags any LED change that was not predicted.
`timescale 1ns/1ps
module tb_seq_00_10_11_ctrl;

   localparam int unsigned DEB = 4;
`ifdef DETECT_COUNT_EN
   localparam bit COUNT_ON = 1'b1;
`else
   localparam bit COUNT_ON = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_FAIL   = 2'b01,
      S_GOT10  = 2'b10,
      S_DETECT = 2'b11
   } st_t;

   typedef struct {
      int unsigned cyc;
      logic [15:0] led;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        exp_q[$];
   logic [1:0]  cur_deb;
   st_t         cur_st;
   logic [7:0]  exp_cnt;
   logic [15:0] last_led = 16'h0000;
   bit          hit;

   seq_00_10_11_ctrl_if pins ();

   seq_00_10_11_ctrl #(.DEB_CYCLES(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pins  (pins)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mk_led(st_t st, logic [1:0] deb, logic [7:0] cnt);
      logic [15:0] v;
      logic [1:0]  s;
      s       = st;
      v       = 16'h0000;
      v[0]    = s[1];
      v[1]    = s[0];
      v[3:2]  = deb;
      v[7]    = (st == S_DETECT);
      v[15:8] = COUNT_ON ? cnt : 8'h00;
      return v;
   endfunction

   function automatic void push(int unsigned at, logic [15:0] led, string tag);
      exp_t e;
      e.cyc = at;
      e.led = led;
      e.tag = tag;
      exp_q.push_back(e);
   endfunction

   // Word w just reached the pins at this negedge: deb_x moves DEB+2 edges later, state one edge after that.
   function automatic void expect_word(logic [1:0] w, st_t nxt, string tag);
      if (w == cur_deb) return;
      push(cyc + DEB + 2, mk_led(cur_st, w, exp_cnt), {tag, "_deb"});
      cur_deb = w;
      if (nxt != cur_st) begin
         if (nxt == S_DETECT) exp_cnt = exp_cnt + 8'd1;
         push(cyc + DEB + 3, mk_led(nxt, w, exp_cnt), {tag, "_st"});
         cur_st = nxt;
      end
   endfunction

   task automatic drive(logic [1:0] w);
      pins.sw_pin = {w, 6'($urandom)};
   endtask

   task automatic step(logic [1:0] w, st_t nxt, string tag, int hold);
      drive(w);
      expect_word(w, nxt, tag);
      repeat (hold) @(negedge clk);
   endtask

   task automatic reset_pulse(int n, logic [1:0] held, st_t nxt, string tag);
      rst_n = 1'b0;
      for (int i = 1; i <= n; i++) push(cyc + i, 16'h0000, tag);
      repeat (n) @(negedge clk);
      rst_n   = 1'b1;
      cur_deb = 2'b00;
      cur_st  = S_IDLE;
      exp_cnt = 8'd0;
      expect_word(held, nxt, {tag, "_rel"});
   endtask

   always @(negedge clk) begin
      hit = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
         n_cmp++;
         if (pins.led_pin !== exp_q[0].led) begin
            n_err++;
            $display("FAIL %s @edge %0d: led_pin=%h required %h", exp_q[0].tag, cyc, pins.led_pin, exp_q[0].led);
         end
         void'(exp_q.pop_front());
         hit = 1'b1;
      end
      if (!hit && pins.led_pin !== last_led) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_change @edge %0d: led_pin=%h required %h", cyc, pins.led_pin, last_led);
      end
      last_led = pins.led_pin;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded 50000 cycles, %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      cur_deb = 2'b00;
      cur_st  = S_IDLE;
      exp_cnt = 8'd0;
      drive(2'b11);

      // Reset with switches at 11, then 11 is accepted from deb_x=00 and IDLE goes to FAIL.
      reset_pulse(3, 2'b11, S_FAIL, "reset");
      repeat (20) @(negedge clk);

      step(2'b00, S_IDLE,   "good_00", 20);
      step(2'b10, S_GOT10,  "good_10", 20);
      step(2'b11, S_DETECT, "good_11", 20);

      step(2'b00, S_IDLE, "bad_00",  20);
      step(2'b11, S_FAIL, "bad_11",  20);
      step(2'b10, S_FAIL, "bad_10",  20);
      step(2'b00, S_IDLE, "bad_ret", 20);

      // Bounce 10/00 with a 3-cycle period: no run reaches DEB, so nothing may move.
      for (int i = 0; i < 10; i++) begin
         drive(2'b10);
         repeat (2) @(negedge clk);
         drive(2'b00);
         @(negedge clk);
      end
      step(2'b10, S_GOT10, "bounce_hold", 20);

      step(2'b01, S_FAIL, "flip_10_01", 20);
      step(2'b00, S_IDLE, "flip_ret",   20);

      // A word stable for DEB-1 cycles then reverting must leave deb_x untouched.
      drive(2'b10);
      repeat (DEB - 1) @(negedge clk);
      drive(2'b00);
      repeat (20) @(negedge clk);

`ifdef DETECT_COUNT_EN
      for (int i = 0; i < 256; i++) begin
         step(2'b00, S_IDLE,   "wrap_00", 10);
         step(2'b10, S_GOT10,  "wrap_10", 10);
         step(2'b11, S_DETECT, "wrap_11", 10);
      end
`endif

      step(2'b00, S_IDLE,  "pre_rst_00", 20);
      step(2'b10, S_GOT10, "pre_rst_10", 20);
      reset_pulse(1, 2'b10, S_GOT10, "mid_reset");
      repeat (20) @(negedge clk);

      while (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: expectation for edge %0d never checked, required %h", exp_q[0].tag, exp_q[0].cyc, exp_q[0].led);
         void'(exp_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_00_10_11_ctrl.md
# seq_00_10_11_ctrl

Synchronous board-level controller for the "00->10->11" sequence detector exercise on EGO1. It synchronizes and debounces the switch pair {x2,x1} as one atomic 2-bit word, so two switches that flip together cannot pass through a spurious intermediate code. It runs the detector as a clocked state machine and drives the state, detect output and an optional detection count onto the LEDs. It sits directly between sw_pin and led_pin at the top of the board design.

## Interface
- DEB_CYCLES, 1_000_000, number of consecutive stable clock cycles required before a new switch word is accepted (10 ms at 100 MHz); legal range >= 1.
- clk  input  1  board clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- sw_pin  input  8  switches; sw_pin[7]=x2, sw_pin[6]=x1, other bits ignored.
- led_pin  output  16  [0]=y2, [1]=y1, [3:2]=debounced {x2,x1}, [7]=z, [15:8]=detection count (macro) else 0, all other bits 0.

## Operation
- Synchronizer: two flip-flop stages on {sw_pin[7], sw_pin[6]}, giving sync_x[1:0].
- Debouncer on the whole 2-bit word:
  - Registers deb_x[1:0] and deb_cnt of width $clog2(DEB_CYCLES+1).
  - If sync_x == deb_x, deb_cnt clears to 0.
  - If sync_x != deb_x and sync_x equals its value on the previous cycle, deb_cnt increments.
  - Any change of sync_x restarts deb_cnt at 1.
  - When deb_cnt reaches DEB_CYCLES, deb_x <= sync_x and deb_cnt <= 0.
  - A glitch shorter than DEB_CYCLES cycles never reaches deb_x.
- FSM on deb_x, state {y2,y1}: IDLE=00, GOT10=10, DETECT=11, FAIL=01. Next-state rules:
  - deb_x=00: any state -> IDLE.
  - deb_x=01: any state -> FAIL.
  - deb_x=10: IDLE or GOT10 -> GOT10; FAIL or DETECT -> FAIL.
  - deb_x=11: GOT10 or DETECT -> DETECT; IDLE or FAIL -> FAIL.
- FAIL is left only via deb_x=00.
- z = (state == DETECT), a registered Moore output.
- The FSM updates every clock. deb_x changes at most once per DEB_CYCLES cycles, so each accepted word causes exactly one transition step; repeated evaluation is idempotent.
- Reset values: sync stages 00, deb_x 00, deb_cnt 0, state IDLE, detection count 0, so all led_pin bits are 0.
- Reset mid-operation: everything returns to its reset value on the first clock edge with rst_n=0. After release, a switch word held at a non-zero value is re-debounced from deb_x=00. Example: switches held at 10 lead to GOT10 after the normal latency.

## Timing
- Switch change to sync_x: 2 edges.
- sync_x stable to deb_x update: DEB_CYCLES edges.
- deb_x to state/z/led_pin[1:0]: 1 edge.
- Total: DEB_CYCLES+3 edges from a clean switch change to the LED update.
- led_pin[3:2] follows deb_x, so it leads the state LEDs by one edge.
- A new word that is stable for exactly DEB_CYCLES-1 cycles and then reverts produces no change to deb_x.

## Configuration
- DETECT_COUNT_EN defined:
  - An 8-bit counter increments on every clock where the state enters DETECT from another state; staying in DETECT does not increment.
  - The counter wraps 255 -> 0 and drives led_pin[15:8].
  - Reset clears it. Re-entering DETECT after IDLE->GOT10 counts again.
- DETECT_COUNT_EN undefined: no counter is built and led_pin[15:8] is constant 0.

## Test plan
- Reset: with DEB_CYCLES=4, hold rst_n=0 for 3 clocks while the switches are at 11 -> led_pin=16'h0000. After release, the switches (still held at 11) are accepted as deb_x=11 and the state goes IDLE->FAIL, so led_pin[1:0]=2'b10 and z=0.
- Good sequence: with DEB_CYCLES=4, apply 00, then 10, then 11, each held 20 cycles.
  - The state goes GOT10 exactly 7 edges after 10 is applied.
  - The state goes DETECT and z=1 exactly 7 edges after 11 is applied.
  - With the macro, count=1.
- Bad order: apply 00->11->10 -> state becomes FAIL at 11 and stays FAIL at 10, z=0 throughout. Returning to 00 restores IDLE.
- Bounce: from deb_x=00, toggle the switch word between 10 and 00 with a 3-cycle period for 30 cycles, then hold 10 -> deb_x stays 00 during the toggling and becomes 10 only DEB_CYCLES+2 edges after the hold begins.
- Simultaneous flip: from GOT10, change both switches 10->01 on the same edge -> deb_x jumps directly 10->01 with no intermediate code, and the state goes FAIL.
- Counter wrap (macro on): repeat 00->10->11 256 times -> count reads 0. A reset pulse mid-sequence (in GOT10) -> state IDLE and count 0 on the next edge.
